// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//
// Front end for the 5-bit key register. Receives PS/2 keyboard frames,
// validates parity and stop bit, swallows break (F0) and extended (E0)
// sequences, translates make codes into key indices and pulses load so the
// key register captures key_code.
//
// Parameters
//   N          key_code width; table indices are zero-extended (N >= 5)
//   FILTER_LEN consecutive equal synced samples before filtered clock moves
//   TIMEOUT    clk cycles without a falling edge before a frame is dropped
//
// Ports
//   clk        system clock, everything on the rising edge
//   rst        synchronous active-high reset
//   ps2_clk    keyboard clock pin (asynchronous, idles high)
//   ps2_data   keyboard data pin (asynchronous, idles high)
//   key_code   last accepted key index, holds until the next load
//   load       one-cycle pulse, key_code is valid
//   frame_err  one-cycle pulse on parity, stop-bit or timeout error
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
   parameter int N          = 5,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic [N-1:0] key_code,
   output logic         load,
   output logic         frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RX    = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   // Table lookup: returns {hit, index}. Codes outside the table miss.
   function automatic logic [5:0] lookup(input logic [7:0] code);
      logic [5:0] r;
      r = 6'd0;
      case (code)
         8'h45: r = {1'b1, 5'd0};
         8'h16: r = {1'b1, 5'd1};
         8'h1E: r = {1'b1, 5'd2};
         8'h26: r = {1'b1, 5'd3};
         8'h25: r = {1'b1, 5'd4};
         8'h2E: r = {1'b1, 5'd5};
         8'h36: r = {1'b1, 5'd6};
         8'h3D: r = {1'b1, 5'd7};
         8'h3E: r = {1'b1, 5'd8};
         8'h46: r = {1'b1, 5'd9};
         8'h1C: r = {1'b1, 5'd10};
         8'h32: r = {1'b1, 5'd11};
         8'h21: r = {1'b1, 5'd12};
         8'h23: r = {1'b1, 5'd13};
         8'h24: r = {1'b1, 5'd14};
         8'h2B: r = {1'b1, 5'd15};
         8'h5A: r = {1'b1, 5'd16};
         8'h66: r = {1'b1, 5'd17};
         8'h76: r = {1'b1, 5'd18};
         default: r = 6'd0;
      endcase
      return r;
   endfunction

   state_t         state_q,     state_d;
   logic [1:0]     clk_sync_q,  clk_sync_d;
   logic [1:0]     data_sync_q, data_sync_d;
   logic           filt_clk_q,  filt_clk_d;
   logic [FW-1:0]  filt_cnt_q,  filt_cnt_d;
   logic           fall_tick_q, fall_tick_d;
   logic [9:0]     shift_q,     shift_d;
   logic [3:0]     bit_cnt_q,   bit_cnt_d;
   logic [TW-1:0]  to_cnt_q,    to_cnt_d;
   logic           brk_q,       brk_d;
   logic           ext_q,       ext_d;
   logic [N-1:0]   key_code_q,  key_code_d;
   logic           load_q,      load_d;
   logic           frame_err_q, frame_err_d;
   logic [5:0]     hit_idx;
   logic           frame_good;

   // Pin synchronisers and the glitch filter. The filtered clock only flips
   // once the synced pin has disagreed with it for FILTER_LEN samples in a
   // row; any agreeing sample restarts the count. fall_tick is registered so
   // it is a clean single-cycle pulse aligned with the synced data bit.
   always_comb begin
      clk_sync_d  = {clk_sync_q[0], ps2_clk};
      data_sync_d = {data_sync_q[0], ps2_data};
      filt_clk_d  = filt_clk_q;
      filt_cnt_d  = '0;
      fall_tick_d = 1'b0;
      if (clk_sync_q[1] != filt_clk_q) begin
         if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_clk_d  = clk_sync_q[1];
            fall_tick_d = filt_clk_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   // Frame good when data plus parity holds an odd number of ones and the
   // stop bit is high. shift_q ends up as {stop, parity, data[7:0]}.
   always_comb begin
      hit_idx    = lookup(shift_q[7:0]);
      frame_good = (^shift_q[8:0]) & shift_q[9];
   end

   // Receive FSM and decoder. Bits arrive LSB first and are shifted in from
   // the top. The CHECK state lasts one cycle and produces the registered
   // load/frame_err, so load lands two cycles after the stop-bit tick.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      to_cnt_d    = to_cnt_q;
      brk_d       = brk_q;
      ext_d       = ext_q;
      key_code_d  = key_code_q;
      load_d      = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            to_cnt_d = '0;
            if (fall_tick_q && !data_sync_q[1]) begin
               state_d   = ST_RX;
               bit_cnt_d = 4'd0;
            end
         end
         ST_RX: begin
            if (fall_tick_q) begin
               shift_d  = {data_sync_q[1], shift_q[9:1]};
               to_cnt_d = '0;
               if (bit_cnt_q == 4'd9) begin
                  state_d = ST_CHECK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
               state_d     = ST_IDLE;
               to_cnt_d    = '0;
               frame_err_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            if (!frame_good) begin
               frame_err_d = 1'b1;
               brk_d       = 1'b0;
               ext_d       = 1'b0;
            end else if (shift_q[7:0] == 8'hF0) begin
               brk_d = 1'b1;
            end else if (shift_q[7:0] == 8'hE0) begin
               ext_d = 1'b1;
            end else begin
               // Releases and extended keys are consumed without output.
               if (!brk_q && !ext_q && hit_idx[5]) begin
                  key_code_d      = '0;
                  key_code_d[4:0] = hit_idx[4:0];
                  load_d          = 1'b1;
               end
               brk_d = 1'b0;
               ext_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // All state lives here. Pins idle high, so the synchronisers and the
   // filtered clock reset to 1 to avoid a false edge coming out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_clk_q  <= 1'b1;
         filt_cnt_q  <= '0;
         fall_tick_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         to_cnt_q    <= '0;
         brk_q       <= 1'b0;
         ext_q       <= 1'b0;
         key_code_q  <= '0;
         load_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         filt_clk_q  <= filt_clk_d;
         filt_cnt_q  <= filt_cnt_d;
         fall_tick_q <= fall_tick_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         to_cnt_q    <= to_cnt_d;
         brk_q       <= brk_d;
         ext_q       <= ext_d;
         key_code_q  <= key_code_d;
         load_q      <= load_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign key_code  = key_code_q;
   assign load      = load_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//
// Drives PS/2 frames into ps2_key_decoder and compares load/frame_err pulse
// counts and key_code against a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

   localparam int N    = 5;
   localparam int FL   = 8;
   localparam int TO   = 3000;
   localparam int HALF = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic         ps2_clk;
   logic         ps2_data;
   logic [N-1:0] key_code;
   logic         load;
   logic         frame_err;

   int errors = 0;
   int checks = 0;
   int load_cnt = 0;
   int err_cnt = 0;
   logic load_prev = 1'b0;

   // Model state: pending break/extended prefixes and the expected key.
   logic         m_brk;
   logic         m_ext;
   logic [N-1:0] m_key;
   int           exp_load;
   int           exp_err;

   logic [7:0] make_tab [19] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h1C, 8'h32,
                                 8'h21, 8'h23, 8'h24, 8'h2B, 8'h5A, 8'h66,
                                 8'h76};

   ps2_key_decoder #(.N(N), .FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_code  (key_code),
      .load      (load),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Pulse monitor on the falling edge: counts load and frame_err pulses and
   // checks every load pulse is one cycle wide and never overlaps frame_err.
   always @(negedge clk) begin
      if (load === 1'b1) begin
         load_cnt++;
         checks++;
         if (frame_err !== 1'b0 || load_prev !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_pulse: frame_err=%b prev_load=%b, required 0 and 0",
                     frame_err, load_prev);
         end
      end
      if (frame_err === 1'b1) err_cnt++;
      load_prev = load;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_bit(input logic b);
      ps2_data = b;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   function automatic int table_index(input logic [7:0] code);
      for (int i = 0; i < 19; i++)
         if (make_tab[i] == code) return i;
      return -1;
   endfunction

   // Frame-level reference: what one complete frame should do.
   task automatic model_frame(input logic [7:0] b, input logic par_good, input logic stop_bit);
      int idx;
      exp_load = 0;
      exp_err  = 0;
      if (!par_good || !stop_bit) begin
         exp_err = 1;
         m_brk   = 1'b0;
         m_ext   = 1'b0;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else begin
         idx = table_index(b);
         if (!m_brk && !m_ext && idx >= 0) begin
            exp_load = 1;
            m_key    = N'(idx);
         end
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   // Sends start, 8 data bits LSB first, parity and stop, then idles long
   // enough for the decoder to finish, and updates the model.
   task automatic applyStimulus(input logic [7:0] b, input logic par_good, input logic stop_bit);
      logic parity;
      parity = par_good ? ~(^b) : ^b;
      apply_bit(1'b0);
      for (int i = 0; i < 8; i++) apply_bit(b[i]);
      apply_bit(parity);
      apply_bit(stop_bit);
      ps2_data = 1'b1;
      wait_cycles(40);
      model_frame(b, par_good, stop_bit);
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cycles(5);
      @(negedge clk);
      checks++;
      if (key_code !== '0 || load !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: key=%h load=%b err=%b, required 0 0 0",
                  key_code, load, frame_err);
      end
      rst = 1'b0;
      m_brk = 1'b0;
      m_ext = 1'b0;
      m_key = '0;
      wait_cycles(5);
   endtask

   task automatic test_basic;
      int l0, e0;
      l0 = load_cnt; e0 = err_cnt;
      applyStimulus(8'h1C, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 1 || err_cnt - e0 !== 0) begin
         errors++;
         $display("[TB] FAIL basic_pulses: loads=%0d errs=%0d, required 1 0", load_cnt - l0, err_cnt - e0);
      end
      checks++;
      if (key_code !== 5'h0A) begin
         errors++;
         $display("[TB] FAIL basic_key: got %h, required 0a", key_code);
      end
   endtask

   task automatic test_break;
      int l0;
      l0 = load_cnt;
      applyStimulus(8'hF0, 1'b1, 1'b1);
      applyStimulus(8'h1C, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 0 || key_code !== 5'h0A) begin
         errors++;
         $display("[TB] FAIL break_release: loads=%0d key=%h, required 0 and 0a", load_cnt - l0, key_code);
      end
      l0 = load_cnt;
      applyStimulus(8'h16, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 1 || key_code !== 5'h01) begin
         errors++;
         $display("[TB] FAIL break_next_make: loads=%0d key=%h, required 1 and 01", load_cnt - l0, key_code);
      end
   endtask

   task automatic test_parity;
      int l0, e0;
      l0 = load_cnt; e0 = err_cnt;
      applyStimulus(8'h45, 1'b0, 1'b1);
      checks++;
      if (err_cnt - e0 !== 1 || load_cnt - l0 !== 0 || key_code !== 5'h01) begin
         errors++;
         $display("[TB] FAIL parity_error: errs=%0d loads=%0d key=%h, required 1 0 01",
                  err_cnt - e0, load_cnt - l0, key_code);
      end
   endtask

   task automatic test_extended;
      int l0;
      l0 = load_cnt;
      applyStimulus(8'hE0, 1'b1, 1'b1);
      applyStimulus(8'h5A, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 0 || key_code !== 5'h01) begin
         errors++;
         $display("[TB] FAIL extended_ignored: loads=%0d key=%h, required 0 and 01", load_cnt - l0, key_code);
      end
      l0 = load_cnt;
      applyStimulus(8'h5A, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 1 || key_code !== 5'h10) begin
         errors++;
         $display("[TB] FAIL enter_make: loads=%0d key=%h, required 1 and 10", load_cnt - l0, key_code);
      end
   endtask

   task automatic test_timeout;
      int l0, e0;
      l0 = load_cnt; e0 = err_cnt;
      apply_bit(1'b0);
      apply_bit(1'b0);
      apply_bit(1'b1);
      apply_bit(1'b1);
      ps2_data = 1'b1;
      wait_cycles(TO + 200);
      checks++;
      if (err_cnt - e0 !== 1 || load_cnt - l0 !== 0 || key_code !== 5'h10) begin
         errors++;
         $display("[TB] FAIL timeout_abort: errs=%0d loads=%0d key=%h, required 1 0 10",
                  err_cnt - e0, load_cnt - l0, key_code);
      end
      l0 = load_cnt;
      applyStimulus(8'h76, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 1 || key_code !== 5'h12) begin
         errors++;
         $display("[TB] FAIL after_timeout: loads=%0d key=%h, required 1 and 12", load_cnt - l0, key_code);
      end
   endtask

   task automatic test_glitch_and_reset;
      int l0, e0;
      l0 = load_cnt; e0 = err_cnt;
      // Short low pulse with data low would look like a start bit if it
      // leaked through the filter and would then misalign the next frame.
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cycles(FL - 2);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cycles(30);
      applyStimulus(8'h16, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 1 || err_cnt - e0 !== 0 || key_code !== 5'h01) begin
         errors++;
         $display("[TB] FAIL glitch_filter: loads=%0d errs=%0d key=%h, required 1 0 01",
                  load_cnt - l0, err_cnt - e0, key_code);
      end
      l0 = load_cnt;
      apply_bit(1'b0);
      for (int i = 0; i < 4; i++) apply_bit(1'b1);
      rst = 1'b1;
      wait_cycles(3);
      @(negedge clk);
      checks++;
      if (key_code !== '0 || load !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midframe_reset: key=%h load=%b err=%b, required 0 0 0",
                  key_code, load, frame_err);
      end
      rst = 1'b0;
      m_brk = 1'b0;
      m_ext = 1'b0;
      m_key = '0;
      wait_cycles(10);
      applyStimulus(8'h2B, 1'b1, 1'b1);
      checks++;
      if (load_cnt - l0 !== 1 || key_code !== 5'h0F) begin
         errors++;
         $display("[TB] FAIL after_reset: loads=%0d key=%h, required 1 and 0f", load_cnt - l0, key_code);
      end
   endtask

   task automatic test_random;
      int l0, e0, sel;
      logic [7:0] b;
      logic pg, sb;
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(99));
         if (sel < 50)      b = make_tab[$urandom_range(18)];
         else if (sel < 65) b = 8'hF0;
         else if (sel < 75) b = 8'hE0;
         else               b = 8'($urandom);
         pg = ($urandom_range(9) != 0);
         sb = ($urandom_range(19) != 0);
         l0 = load_cnt; e0 = err_cnt;
         applyStimulus(b, pg, sb);
         checks++;
         if (load_cnt - l0 !== exp_load || err_cnt - e0 !== exp_err) begin
            errors++;
            $display("[TB] FAIL random_pulses[%0d] byte=%h: loads=%0d errs=%0d, required %0d %0d",
                     n, b, load_cnt - l0, err_cnt - e0, exp_load, exp_err);
         end
         checks++;
         if (key_code !== m_key) begin
            errors++;
            $display("[TB] FAIL random_key[%0d] byte=%h: got %h, required %h", n, b, key_code, m_key);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_break();
      test_parity();
      test_extended();
      test_timeout();
      test_glitch_and_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
